// File: rtl/axil_pkg.sv
// Shared AXI-Lite constants and helpers for the CSR bridge.
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam int         AXIL_PROT_W      = 3;

    // Width of a down-counter that starts at timeout-1.
    function automatic int axil_timeout_w(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/axilite_reg_wr.sv
// AXI-Lite write-channel slave driving a register-file write strobe interface.
// Optional macro AXIL_WR_SLVERR_EN: timeout completions answer with SLVERR.
module axilite_reg_wr
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 40,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,

    input  logic [ADDR_WIDTH-1:0]  s_axil_awaddr,
    input  logic [AXIL_PROT_W-1:0] s_axil_awprot,
    input  logic                   s_axil_awvalid,
    output logic                   s_axil_awready,
    input  logic [DATA_WIDTH-1:0]  s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]  s_axil_wstrb,
    input  logic                   s_axil_wvalid,
    output logic                   s_axil_wready,
    output logic [1:0]             s_axil_bresp,
    output logic                   s_axil_bvalid,
    input  logic                   s_axil_bready,

    output logic [ADDR_WIDTH-1:0]  reg_wr_addr,
    output logic [DATA_WIDTH-1:0]  reg_wr_data,
    output logic [STRB_WIDTH-1:0]  reg_wr_strb,
    output logic                   reg_wr_en,
    input  logic                   reg_wr_wait,
    input  logic                   reg_wr_ack
);

    localparam int               CNT_W    = axil_timeout_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    logic             aw_held, aw_held_nxt;
    logic             w_held, w_held_nxt;
    logic             bvalid_nxt;
    logic             en_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             aw_fire, w_fire, complete;

    // awprot carries no meaning for the register file.
    logic unused_awprot;
    assign unused_awprot = &{1'b0, s_axil_awprot};

    assign s_axil_awready = !aw_held;
    assign s_axil_wready  = !w_held;

    always_comb begin
        aw_fire     = s_axil_awvalid && !aw_held;
        w_fire      = s_axil_wvalid && !w_held;
        complete    = reg_wr_en && (reg_wr_ack || cnt == '0);

        aw_held_nxt = complete ? 1'b0 : (aw_held || aw_fire);
        w_held_nxt  = complete ? 1'b0 : (w_held || w_fire);

        bvalid_nxt  = s_axil_bvalid;
        if (complete)
            bvalid_nxt = 1'b1;
        else if (s_axil_bvalid && s_axil_bready)
            bvalid_nxt = 1'b0;

        // A pending B response blocks the next strobe until it is accepted.
        en_nxt      = aw_held_nxt && w_held_nxt && !bvalid_nxt;

        cnt_nxt     = cnt;
        if (!reg_wr_en)
            cnt_nxt = CNT_LOAD;
        else if (!reg_wr_wait && cnt != '0)
            cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axil_bvalid <= 1'b0;
            reg_wr_en     <= 1'b0;
            cnt           <= '0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
            reg_wr_strb   <= '0;
        end else begin
            aw_held       <= aw_held_nxt;
            w_held        <= w_held_nxt;
            s_axil_bvalid <= bvalid_nxt;
            reg_wr_en     <= en_nxt;
            cnt           <= cnt_nxt;
            if (aw_fire)
                reg_wr_addr <= s_axil_awaddr;
            if (w_fire) begin
                reg_wr_data <= s_axil_wdata;
                reg_wr_strb <= s_axil_wstrb;
            end
        end
    end

`ifdef AXIL_WR_SLVERR_EN
    logic [1:0] bresp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            bresp_q <= AXIL_RESP_OKAY;
        else if (complete)
            bresp_q <= reg_wr_ack ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
    end

    assign s_axil_bresp = bresp_q;
`else
    assign s_axil_bresp = AXIL_RESP_OKAY;
`endif

endmodule

// File: doc/axilite_reg_wr.md
Name: axilite_reg_wr

Overview:
- AXI-Lite write-channel slave that converts AW/W/B handshakes into a single-cycle-per-access register-write strobe interface.
- Write-direction counterpart of the AXI-Lite register read bridge; the two are paired to form the full CSR port of the accelerator.
- Sits between the host AXI-Lite interconnect and the CSR/config register file.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width in bits.
- ADDR_WIDTH, 40, AXI-Lite address width in bits.
- STRB_WIDTH, DATA_WIDTH/8, wstrb width (bytes per word).
- TIMEOUT, 4, max reg_wr_en cycles (not counting wait cycles) before a forced completion; must be ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid  in  1  AW valid.
- s_axil_awready  out  1  AW ready.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte strobes.
- s_axil_wvalid  in  1  W valid.
- s_axil_wready  out  1  W ready.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1  B valid.
- s_axil_bready  in  1  B ready.
- reg_wr_addr  out  ADDR_WIDTH  held AW address.
- reg_wr_data  out  DATA_WIDTH  held W data.
- reg_wr_strb  out  STRB_WIDTH  held W strobes.
- reg_wr_en  out  1  write strobe; high until ack/timeout.
- reg_wr_wait  in  1  register file stall; freezes the timeout counter.
- reg_wr_ack  in  1  register file accepted the write.

Behaviour:
- Reset: awready=1, wready=1, bvalid=0, bresp=2'b00, reg_wr_en=0, reg_wr_addr/data/strb=0, timeout count=0, AW/W hold flags=0.
- AW and W are captured independently into one-entry holds. awready = !aw_held and wready = !w_held (both registered-flag derived, no combinational path from valid to ready).
- Either channel may arrive first or in the same cycle. A captured channel stays held until its access completes.
- Issue: reg_wr_en_next = aw_held_next && w_held_next && !bvalid_next. The strobe asserts the cycle after the later of AW/W is captured.
- Timeout counter:
  - Loads TIMEOUT-1 while reg_wr_en=0.
  - Decrements each cycle with reg_wr_en=1 and reg_wr_wait=0, saturating at 0.
  - Holds while reg_wr_wait=1.
- Completion occurs in a cycle where reg_wr_en && (reg_wr_ack || count==0). Next cycle:
  - aw_held=0, w_held=0, bvalid=1, reg_wr_en=0.
  - awready=wready=1 again.
- Latency: AW+W together at t0, ack at t1 → reg_wr_en high at t1 only, bvalid at t2.
- No ack: reg_wr_en stays high for TIMEOUT non-wait cycles, then bvalid.
- bvalid holds until bready. bvalid && bready clears bvalid next cycle.
- New AW/W may be captured while bvalid is pending, but reg_wr_en is not issued until bvalid_next=0. When bready is accepted in cycle t and holds are full, reg_wr_en asserts at t+1.
- Simultaneous ack and wait: ack wins, completion.
- wstrb=0: the write is still issued, with reg_wr_strb=0.
- reg_wr_addr/data/strb are stable for the whole reg_wr_en period.
- Reset mid-operation: the in-flight write is dropped and no B response is produced; all outputs return to reset values immediately.

Optional Feature:
- AXIL_WR_SLVERR_EN defined: a completion caused by timeout without ack returns bresp=2'b10 (SLVERR); an acked write returns 2'b00. bresp is registered alongside bvalid and reset to 2'b00.
- Not defined: bresp is constant 2'b00 and no error flag is stored.

Decomposition:
- Shared package axil_pkg holds:
  - localparams AXIL_RESP_OKAY=2'b00 and AXIL_RESP_SLVERR=2'b10.
  - AXIL_PROT_W=3.
  - The timeout width rule, $clog2(TIMEOUT).
- No sub-module: both holds are two instances of the same valid/ready flag pattern and stay inline.

Test Plan:
- AW+W same cycle (addr 0x10, data 0xDEADBEEF, strb 4'hF), ack tied 1 → reg_wr_en high exactly 1 cycle with those values; bvalid next cycle with bresp 0; awready/wready return to 1.
- W 3 cycles before AW (addr 0x20) → wready low after W capture; reg_wr_en asserts the cycle after AW capture; data is the earlier W.
- ack=0, wait=0, TIMEOUT=4 → reg_wr_en high 4 cycles, then bvalid. bresp=2'b10 with AXIL_WR_SLVERR_EN, 2'b00 without.
- ack=0, wait=1 for 5 cycles then 0 → reg_wr_en high 5+4 cycles before timeout completion.
- bready held 0 for 6 cycles while a second AW/W arrives → second reg_wr_en asserts only the cycle after the first B handshake; two B responses in order.
- rstn pulsed low while reg_wr_en=1 → reg_wr_en, bvalid drop asynchronously; no B after release; next write completes normally.
